mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/cnn_pkg.sv | 13 +
 rtl/sat_shift.sv | 35 +++
 rtl/mac_accumulator.sv | 96 +++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN block definitions: default datapath widths and the MAC FSM state encoding.
package cnn_pkg;

    localparam int CNN_IN_D_W = 8;
    localparam int CNN_SHIFT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } mac_state_e;

endpackage

// File: rtl/sat_shift.sv
// Combinational post-processing: arithmetic shift, saturation to Out_W, optional ReLU.
// ReLU clamp is enabled by defining MAC_ACCUMULATOR_RELU_EN.
module sat_shift #(
    parameter int Acc_W = 20,
    parameter int Out_W = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [Acc_W-1:0] i_sum,
    output logic signed [Out_W-1:0] o_res
);

    localparam logic signed [Acc_W-1:0] MAXV = Acc_W'((1 << (Out_W - 1)) - 1);
    // Bitwise complement of 2^(n-1)-1 is exactly -2^(n-1).
    localparam logic signed [Acc_W-1:0] MINV = ~MAXV;

    logic signed [Acc_W-1:0] w_sh;
    logic signed [Out_W-1:0] w_sat;

    always_comb begin
        w_sh = i_sum >>> SHIFT;
        if (w_sh > MAXV)
            w_sat = MAXV[Out_W-1:0];
        else if (w_sh < MINV)
            w_sat = MINV[Out_W-1:0];
        else
            w_sat = w_sh[Out_W-1:0];
    end

`ifdef MAC_ACCUMULATOR_RELU_EN
    assign o_res = w_sat[Out_W-1] ? '0 : w_sat;
`else
    assign o_res = w_sat;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// N_TAPS-deep multiply-accumulate of unsigned pixels by signed weights, with valid/ready on both sides.
// Optional ReLU on the result via MAC_ACCUMULATOR_RELU_EN (implemented in sat_shift).
module mac_accumulator import cnn_pkg::*; #(
    parameter int In_d_W = CNN_IN_D_W,
    parameter int N_TAPS = 9,
    parameter int SHIFT  = CNN_SHIFT,
    parameter int Acc_W  = 2 * In_d_W + 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [In_d_W-1:0] in_pix,
    input  logic signed [In_d_W-1:0] in_wt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [In_d_W-1:0] out_data,
    output logic                     first_tap
);

    localparam int              CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);

    mac_state_e              r_state, w_state_nxt;
    logic                    r_run;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [Acc_W-1:0] r_acc;

    logic                    w_accept, w_last, w_hs;
    logic signed [Acc_W-1:0] w_pix_x, w_wt_x, w_prod, w_sum;
    logic signed [In_d_W-1:0] w_res;

    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_cnt == LAST);
    assign w_hs     = out_valid && out_ready;

    // Pixel is zero-extended into a positive signed value before the multiply.
    assign w_pix_x = Acc_W'($signed({1'b0, in_pix}));
    assign w_wt_x  = Acc_W'(in_wt);
    assign w_prod  = w_pix_x * w_wt_x;
    assign w_sum   = (r_cnt == '0) ? w_prod : r_acc + w_prod;

    sat_shift #(
        .Acc_W (Acc_W),
        .Out_W (In_d_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .i_sum (w_sum),
        .o_res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Outputs decode only registered state, so out_ready never reaches in_ready combinationally.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = r_run && (r_state != ST_HOLD);
        out_valid   = (r_state == ST_HOLD);
        first_tap   = r_run && (r_cnt == '0) && (r_state != ST_HOLD);
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_last ? ST_HOLD : ST_ACC;
            ST_ACC:  if (w_last)   w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_hs)     w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
        if (clr)
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            out_data <= '0;
        end else begin
            r_run <= 1'b1;
            if (clr) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last)
                    out_data <= w_res;
            end
        end
    end

endmodule
